// File: rtl/registrador_8bit.sv
// WIDTH-bit edge-triggered register with synchronous clear (clr, active-high)
// and synchronous preset (pr, active-low); clear wins over preset.

module registrador_8bit_cell (
    input  logic clk,
    input  logic d,
    input  logic pr,
    input  logic clr,
    output logic q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= 1'b0;
        end else if (!pr) begin
            q <= 1'b1;
        end else begin
            q <= d;
        end
    end

endmodule

module registrador_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    input  logic             pr,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    // One identical cell per bit, all sharing clock, preset and clear.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        registrador_8bit_cell u_cell (
            .clk (clk),
            .d   (d[i]),
            .pr  (pr),
            .clr (clr),
            .q   (q[i])
        );
    end

endmodule

// File: tb/tb_registrador_8bit.sv
// Scoreboard bench for registrador_8bit: the driver pushes the expected q for
// every clock edge, and a negedge monitor pops and compares.

module tb_registrador_8bit;

    localparam int WIDTH = 8;

    logic             clk;
    logic [WIDTH-1:0] d;
    logic             pr;
    logic             clr;
    logic [WIDTH-1:0] q;

    logic [WIDTH-1:0] exp_q[$];
    int tests;
    int fails;

    registrador_8bit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .d   (d),
        .pr  (pr),
        .clr (clr),
        .q   (q)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: what q must hold after an edge that sampled these inputs.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] dv,
                                               input logic pv, input logic cv);
        logic [WIDTH-1:0] ones;
        ones = '1;
        if (cv === 1'b1) return '0;
        if (pv === 1'b0) return ones;
        return dv;
    endfunction

    // Apply inputs just after a falling edge, then record expectation at the rising edge.
    task automatic drive(input logic [WIDTH-1:0] dv, input logic pv, input logic cv);
        @(negedge clk);
        #1;
        d   = dv;
        pr  = pv;
        clr = cv;
        @(posedge clk);
        exp_q.push_back(model(dv, pv, cv));
    endtask

    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("q_after_edge", q, e);
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        d   = 'x;
        pr  = 1'b1;
        clr = 1'b0;

        // Power-up: undefined data propagates, then clear takes over.
        drive('x, 1'b1, 1'b0);
        drive(8'hFF, 1'b1, 1'b1);

        // Load, with d disturbed mid-cycle after the capturing edge.
        drive(8'hA5, 1'b1, 1'b0);
        #3 d = 8'h5A;
        drive(8'h3C, 1'b1, 1'b0);
        #3 d = 8'hC3;

        // Preset, then release.
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h12, 1'b1, 1'b0);

        // Clear beats preset; releasing clear with preset still low gives all ones.
        drive(8'h55, 1'b0, 1'b1);
        drive(8'h55, 1'b0, 1'b0);

        // Control pulses strictly between edges must not disturb q.
        drive(8'h81, 1'b1, 1'b0);
        #3;
        clr = 1'b1;
        #2 check("clr_between_edges", q, 8'h81);
        #2 clr = 1'b0;
        drive(8'h81, 1'b1, 1'b0);
        #3;
        pr = 1'b0;
        #2 check("pr_between_edges", q, 8'h81);
        #2 pr = 1'b1;
        drive(8'h81, 1'b1, 1'b0);

        // Randomized traffic with occasional clear/preset.
        for (int i = 0; i < 300; i++) begin
            drive(WIDTH'($urandom), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 3) == 0) #3 d = WIDTH'($urandom);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
